// File: rtl/blockchain_decipher_pkg.sv
// Shared widths, FSM state and the inverse cipher primitives.
// Round keys are a 3-bit-per-round rotation of the 20-bit key.
package blockchain_decipher_pkg;

    localparam int BLOCK_W        = 16;
    localparam int KEY_W          = 20;
    localparam int NUM_BLOCKS_DEF = 8;
    localparam int ROUNDS         = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Inverse of the PRESENT S-box, nibble x at bits [4x+3:4x]
    localparam logic [63:0] SINV = 64'hA970_364B_D21C_8FE5;

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        return SINV[4*x +: 4];
    endfunction

    // Bit i moves to 4i mod 15; for 16 bits this is its own inverse
    function automatic logic [BLOCK_W-1:0] p_layer(
        input logic [BLOCK_W-1:0] s
    );
        logic [BLOCK_W-1:0] o;
        o     = '0;
        o[15] = s[15];
        for (int i = 0; i < 15; i++) begin
            o[(i*4)%15] = s[i];
        end
        return o;
    endfunction

    function automatic logic [BLOCK_W-1:0] round_key(
        input logic [KEY_W-1:0] k,
        input logic [2:0]       r
    );
        logic [KEY_W-1:0] rot;
        rot = (k << (3*r)) | (k >> (KEY_W - 3*r));
        return rot[BLOCK_W-1:0]
             ^ BLOCK_W'(rot[KEY_W-1:BLOCK_W])
             ^ BLOCK_W'(r);
    endfunction

endpackage

// File: rtl/blockchain_decipher_if.sv
// Ciphertext-in / plaintext-out valid-ready stream bundle.
interface blockchain_decipher_if;
    import blockchain_decipher_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_block;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_block;
    logic               out_last;

    modport master (
        output in_valid, in_block, out_ready,
        input  in_ready, out_valid, out_block, out_last
    );

    modport slave (
        input  in_valid, in_block, out_ready,
        output in_ready, out_valid, out_block, out_last
    );

endinterface

// File: rtl/present_decipher.sv
// Combinational inverse of the 4-round 16-bit present_encipher.
// Rounds undo: key add, S-box layer, permutation (last key first).
module present_decipher
    import blockchain_decipher_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_block,
    input  logic [KEY_W-1:0]   i_key,
    output logic [BLOCK_W-1:0] o_block
);

    logic [BLOCK_W-1:0] w_s;

    always_comb begin
        w_s = i_block ^ round_key(i_key, 3'(ROUNDS));
        for (int r = ROUNDS - 1; r >= 0; r--) begin
            w_s = p_layer(w_s);
            for (int n = 0; n < 4; n++) begin
                w_s[4*n +: 4] = sbox_inv(w_s[4*n +: 4]);
            end
            w_s = w_s ^ round_key(i_key, 3'(r));
        end
        o_block = w_s;
    end

endmodule

// File: rtl/blockchain_decipher.sv
// CBC-mode block decipher for NUM_BLOCKS-block messages.
// BLOCKCHAIN_DECIPHER_PIPE_EN adds a register stage before the XOR.
module blockchain_decipher
    import blockchain_decipher_pkg::*;
#(
    parameter int NUM_BLOCKS = NUM_BLOCKS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BLOCK_W-1:0]   init_vec,
    input  logic [KEY_W-1:0]     key,
    blockchain_decipher_if.slave bus,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_BLOCKS - 1);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [KEY_W-1:0]   r_key;
    logic [BLOCK_W-1:0] r_chain;
    logic               r_out_valid;
    logic [BLOCK_W-1:0] r_out_block;
    logic               r_out_last;
    logic               r_done;

    logic [BLOCK_W-1:0] w_dec;
    logic               w_in_ready;
    logic               w_acc;
    logic               w_take;
    logic               w_is_last;

    present_decipher u_dec (
        .i_block (bus.in_block),
        .i_key   (r_key),
        .o_block (w_dec)
    );

    assign w_take    = r_out_valid && bus.out_ready;
    assign w_is_last = (r_cnt == LAST);
    assign w_acc     = bus.in_valid && w_in_ready;

`ifdef BLOCKCHAIN_DECIPHER_PIPE_EN
    logic               r_s1_valid;
    logic [BLOCK_W-1:0] r_s1_dec;
    logic [BLOCK_W-1:0] r_s1_chain;
    logic               r_s1_last;
    logic               w_s2_free;
    logic               w_s1_free;

    assign w_s2_free  = !r_out_valid || bus.out_ready;
    assign w_s1_free  = !r_s1_valid || w_s2_free;
    assign w_in_ready = (r_state == RUN) && w_s1_free;
`else
    assign w_in_ready = (r_state == RUN)
                     && (!r_out_valid || bus.out_ready);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_key       <= '0;
            r_chain     <= '0;
            r_out_valid <= 1'b0;
            r_out_block <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
`ifdef BLOCKCHAIN_DECIPHER_PIPE_EN
            r_s1_valid  <= 1'b0;
            r_s1_dec    <= '0;
            r_s1_chain  <= '0;
            r_s1_last   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_key   <= key;
                        r_chain <= init_vec;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_acc) begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_chain <= bus.in_block;
                        if (w_is_last) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_take && r_out_last) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

`ifdef BLOCKCHAIN_DECIPHER_PIPE_EN
            if (w_s1_free) begin
                r_s1_valid <= w_acc;
                if (w_acc) begin
                    r_s1_dec   <= w_dec;
                    r_s1_chain <= r_chain;
                    r_s1_last  <= w_is_last;
                end
            end
            if (w_s2_free) begin
                r_out_valid <= r_s1_valid;
                r_out_last  <= r_s1_valid && r_s1_last;
                if (r_s1_valid) r_out_block <= r_s1_dec ^ r_s1_chain;
            end
`else
            if (w_acc) begin
                r_out_valid <= 1'b1;
                r_out_block <= w_dec ^ r_chain;
                r_out_last  <= w_is_last;
            end else if (w_take) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
`endif
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_block = r_out_block;
    assign bus.out_last  = r_out_last;
    assign busy          = (r_state != IDLE);
    assign done          = r_done;

endmodule

// File: tb/tb_blockchain_decipher.sv
// Directed bench: a forward-cipher CBC model builds ciphertext tables
// which the DUT must decrypt back to the original plaintext.
module tb_blockchain_decipher;

    localparam int NB = 8;
`ifdef BLOCKCHAIN_DECIPHER_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] init_vec;
    logic [19:0] key;
    logic        busy;
    logic        done;

    blockchain_decipher_if bus ();

    blockchain_decipher #(.NUM_BLOCKS(NB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .init_vec (init_vec),
        .key      (key),
        .bus      (bus.slave),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ct;
        logic [15:0] pt;
        logic        last;
    } vec_t;

    vec_t tbl [NB];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;
            4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;
            4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;
            4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;
            4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    function automatic logic [15:0] perm(input logic [15:0] s);
        logic [15:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[(i == 15) ? 15 : (i*4) % 15] = s[i];
        end
        return o;
    endfunction

    function automatic logic [15:0] rkey(input logic [19:0] k, input int r);
        logic [19:0] t;
        t = k;
        for (int j = 0; j < 3*r; j++) t = {t[18:0], t[19]};
        return t[15:0] ^ {12'h000, t[19:16]} ^ 16'(r);
    endfunction

    function automatic logic [15:0] enc(input logic [15:0] p,
                                        input logic [19:0] k);
        logic [15:0] s;
        s = p;
        for (int r = 0; r < 4; r++) begin
            s = s ^ rkey(k, r);
            for (int n = 0; n < 4; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
            s = perm(s);
        end
        return s ^ rkey(k, 4);
    endfunction

    task automatic fill_rt(input logic [15:0] iv, input logic [19:0] k,
                           input logic [15:0] base);
        logic [15:0] ch;
        ch = iv;
        for (int i = 0; i < NB; i++) begin
            tbl[i].pt   = base + 16'(i);
            tbl[i].ct   = enc(tbl[i].pt ^ ch, k);
            tbl[i].last = (i == NB - 1);
            ch          = tbl[i].ct;
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        start         = 1'b0;
        init_vec      = '0;
        key           = '0;
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] iv, input logic [19:0] k);
        start    = 1'b1;
        init_vec = iv;
        key      = k;
        @(posedge clk);
        #1;
        start    = 1'b0;
        init_vec = ~iv;
        key      = ~k;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic run_msg(input string tag, input logic [15:0] iv,
                           input logic [19:0] k, input int stall_blk,
                           input int stall_len, input bit glitch);
        int ii = 0, oi = 0, cyc = 0, done_cnt = 0;
        int acc_cyc = -1, ov_cyc = -1, first_take = -1, last_take = -1;
        int stall_left = stall_len;
        logic [15:0] held = '0;
        do_start(iv, k);
        while (done_cnt == 0 && cyc < 200) begin
            bus.in_valid  = glitch || (ii < NB);
            bus.in_block  = (ii < NB) ? tbl[ii].ct : 16'hDEAD;
            bus.out_ready = !(oi == stall_blk && stall_left > 0);
            if (glitch && oi < NB) begin
                start    = 1'b1;
                key      = 20'($urandom);
                init_vec = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) done_cnt++;
            if (bus.out_valid && ov_cyc < 0) ov_cyc = cyc;
            if (bus.out_valid && !bus.out_ready) begin
                chk({tag, "_stall_in_ready"}, bus.in_ready, 0);
                if (stall_left < stall_len)
                    chk({tag, "_stall_hold"}, bus.out_block, held);
                held = bus.out_block;
                stall_left--;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (oi < NB) begin
                    chk($sformatf("%s_blk%0d", tag, oi),
                        bus.out_block, tbl[oi].pt);
                    chk($sformatf("%s_last%0d", tag, oi),
                        bus.out_last, tbl[oi].last);
                end
                if (first_take < 0) first_take = cyc;
                last_take = cyc;
                oi++;
            end
            if (bus.in_valid && bus.in_ready) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                ii++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start        = 1'b0;
        bus.in_valid = 1'b0;
        chk({tag, "_no_timeout"}, 32'(cyc < 200), 1);
        repeat (3) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_n_out"}, oi, NB);
        chk({tag, "_n_in"}, ii, NB);
        chk({tag, "_latency"}, 32'(ov_cyc - acc_cyc), LAT);
        chk({tag, "_busy_end"}, busy, 0);
        if (stall_len == 0)
            chk({tag, "_back2back"}, 32'(last_take - first_take), NB - 1);
    endtask

    initial begin
        logic [15:0] d;
        do_reset();
        chk("reset_state", {bus.out_valid, bus.out_last, done, busy,
                            bus.in_ready, bus.out_block}, 0);

        // in_valid while idle must not be accepted
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_block = 16'(16'h5000 + i);
            @(negedge clk);
            chk("idle_in_valid", {bus.in_ready, busy, bus.out_valid}, 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;

        fill_rt(16'hA5A5, 20'h12345, 16'h0000);
        run_msg("rt", 16'hA5A5, 20'h12345, -1, 0, 1'b0);

        fill_rt(16'hA5A5, 20'h12345, 16'h0000);
        run_msg("bp", 16'hA5A5, 20'h12345, 4, 3, 1'b0);

        d = '0;
        for (int v = 0; v < 65536; v++)
            if (enc(16'(v), 20'h12345) == 16'h1234) d = 16'(v);
        for (int i = 0; i < NB; i++) begin
            tbl[i].ct   = 16'h1234;
            tbl[i].pt   = (i == 0) ? (d ^ 16'hA5A5) : (d ^ 16'h1234);
            tbl[i].last = (i == NB - 1);
        end
        run_msg("chain", 16'hA5A5, 20'h12345, -1, 0, 1'b0);

        // asynchronous reset after four blocks have been accepted
        fill_rt(16'hA5A5, 20'h12345, 16'h0000);
        do_start(16'hA5A5, 20'h12345);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_block = tbl[i].ct;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("pre_rst_valid", bus.out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {bus.out_valid, bus.out_last, done, busy,
                                bus.in_ready, bus.out_block}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        fill_rt(16'h3C3C, 20'hABCDE, 16'h0100);
        run_msg("recover", 16'h3C3C, 20'hABCDE, -1, 0, 1'b0);

        fill_rt(16'h5A5A, 20'h0F0F0, 16'h7770);
        run_msg("proto", 16'h5A5A, 20'h0F0F0, -1, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blockchain_decipher.md
BLOCKCHAIN_DECIPHER -- requirements
Module: blockchain_decipher

Interface
REQ-001 Parameter NUM_BLOCKS, default 8, SHALL set the number of 16-bit blocks per message (legal range 1..256).
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port start, input, 1: request to begin a message; sampled only in IDLE.
REQ-005 Port init_vec, input, 16: CBC initialisation vector; sampled on an accepted start.
REQ-006 Port key, input, 20: cipher key; sampled on an accepted start.
REQ-007 Port in_valid, input, 1: ciphertext block offered.
REQ-008 Port in_ready, output, 1: block accepted when in_valid && in_ready.
REQ-009 Port in_block, input, 16: ciphertext block C_i.
REQ-010 Port out_valid, output, 1: plaintext block held.
REQ-011 Port out_ready, input, 1: sink takes the block when out_valid && out_ready.
REQ-012 Port out_block, output, 16: plaintext block P_i.
REQ-013 Port out_last, output, 1: high with out_valid on block NUM_BLOCKS-1.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port done, output, 1: one-cycle pulse when the last block is taken.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-017 IDLE with start=1 SHALL latch key into the key register and init_vec into the chain register, clear the block counter, and move to RUN.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 Each accepted C_i SHALL produce P_i = D(key_reg, C_i) XOR chain, and SHALL load chain <= C_i in the same edge.
REQ-020 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready), so the path is full-throughput with simultaneous take/accept.
REQ-021 Latency SHALL be 1 cycle from acceptance to out_valid; out_block and out_last SHALL stay stable while out_valid && !out_ready.
REQ-022 The block counter SHALL increment per acceptance; accepting block NUM_BLOCKS-1 SHALL move RUN->DRAIN and deassert in_ready from the next cycle.
REQ-023 In DRAIN, the take of the out_last block SHALL pulse done for one cycle and return the FSM to IDLE.
REQ-024 in_valid in IDLE or DRAIN SHALL be ignored, with no acceptance.
REQ-025 key and init_vec changes after start SHALL have no effect on the running message.

Reset
REQ-026 rst SHALL force IDLE, counter 0, chain and key registers 0, out_valid=0, out_block=0, out_last=0, done=0 and busy=0, including mid-message; the partial message is discarded.

Configuration
REQ-027 With BLOCKCHAIN_DECIPHER_PIPE_EN defined, the D() result and the chain value SHALL be registered before the XOR, giving a latency of 2.
REQ-028 In that build, in_ready SHALL drop only when both stages are full and out_ready=0, and throughput SHALL remain one block per cycle.
REQ-029 Without BLOCKCHAIN_DECIPHER_PIPE_EN, REQ-021 latency 1 applies.

Structure
REQ-030 A shared package SHALL hold BLOCK_W=16, KEY_W=20, the FSM state enum and the default NUM_BLOCKS.
REQ-031 D() SHALL be one instance of the combinational inverse cipher sub-module present_decipher (block, key -> plaintext), the exact inverse of present_encipher.

Verification
REQ-032 Round trip: plaintext 0x0000..0x0007, IV 0xA5A5, key 0x12345, enciphered by blockchain_encipher and streamed in back-to-back -> out_block = 0x0000..0x0007 on consecutive cycles, out_last on the 8th block, then one done pulse.
REQ-033 Backpressure: same stimulus with out_ready low for 3 cycles at block 4 -> in_ready low and out_block held stable, with no loss or duplication.
REQ-034 Chaining: all ciphertext blocks 0x1234 -> P_0 = D(0x1234) ^ 0xA5A5 and P_1..P_7 = D(0x1234) ^ 0x1234.
REQ-035 Reset: rst asserted after block 3 is accepted -> all outputs 0 immediately; a new start then decrypts correctly with fresh IV and key.
REQ-036 Protocol: start while busy, and in_valid in IDLE -> no state change and no acceptance.
REQ-037 Configuration: the round trip is repeated with BLOCKCHAIN_DECIPHER_PIPE_EN defined -> identical data, with first out_valid 2 cycles after the first acceptance.
